// File: rtl/adxl362_spi_master.sv
// SPI initiator for ADXL362-style 24-bit register frames (command, address, data)
// with an optional autonomous four-register Y/Z axis poll.
module adxl362_spi_master #(
  parameter logic [7:0] READ_CMD  = 8'h0B,
  parameter logic [7:0] WRITE_CMD = 8'h0A,
  parameter logic [7:0] AXIS_BASE = 8'h10,
  parameter int         CS_GAP    = 1
) (
  input  logic        SCLK,
  input  logic        resetn,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  input  logic        poll_en,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        CS,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);
  localparam logic [4:0] FRAME_BITS = 5'd24;
  localparam logic [4:0] RX_FIRST = 5'd16;

  state_t      state;
  logic [4:0]  bitcnt;
  logic [3:0]  gap_cnt;
  logic [1:0]  idx;
  logic        frame_rd;
  logic        frame_poll;
  logic [23:0] frame;
  logic [7:0]  rx;
  logic [7:0]  slot0;
  logic [7:0]  slot1;
  logic [7:0]  slot2;

  logic launch_cpu;
  logic launch_poll;
  logic shifting;
  logic finishing;
  logic poll_commit;

  always_comb begin
    launch_cpu  = (state == IDLE) && start;
    launch_poll = (state == IDLE) && !start && poll_en;
    shifting    = (state == SHIFT) && (bitcnt != FRAME_BITS);
    finishing   = (state == SHIFT) && (bitcnt == FRAME_BITS);
    poll_commit = finishing && frame_poll && poll_en;
  end

  // Frame shifter, receive shifter and poll slots carry no reset: they are
  // always rewritten before being consumed.
  always_ff @(posedge SCLK) begin
    if (launch_cpu) begin
      frame <= {rw ? READ_CMD : WRITE_CMD, addr, rw ? 8'h00 : wdata};
    end else if (launch_poll) begin
      frame <= {READ_CMD, AXIS_BASE + {6'd0, idx}, 8'h00};
    end else if (shifting) begin
      frame <= {frame[22:0], 1'b0};
    end

    if (shifting && (bitcnt >= RX_FIRST)) begin
      rx <= {rx[6:0], MISO};
    end

    if (poll_commit) begin
      case (idx)
        2'd0:    slot0 <= rx;
        2'd1:    slot1 <= rx;
        2'd2:    slot2 <= rx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (!resetn) begin
      state        <= IDLE;
      bitcnt       <= 5'd0;
      gap_cnt      <= 4'd0;
      idx          <= 2'd0;
      frame_rd     <= 1'b0;
      frame_poll   <= 1'b0;
      CS           <= 1'b1;
      MOSI         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= 8'h00;
      y_data       <= 16'h0000;
      z_data       <= 16'h0000;
      sample_valid <= 1'b0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      // Dropping poll_en abandons any partially gathered sample.
      if (!poll_en) begin
        idx <= 2'd0;
      end

      case (state)
        IDLE: begin
          CS   <= 1'b1;
          MOSI <= 1'b0;
          if (launch_cpu || launch_poll) begin
            frame_rd   <= launch_cpu ? rw : 1'b1;
            frame_poll <= launch_poll;
            CS         <= 1'b0;
            bitcnt     <= 5'd0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end

        SHIFT: begin
          if (shifting) begin
            bitcnt <= bitcnt + 5'd1;
            MOSI   <= frame[23];
          end else begin
            CS   <= 1'b1;
            MOSI <= 1'b0;
            if (frame_poll) begin
              if (poll_en) begin
                if (idx == 2'd3) begin
                  y_data       <= {slot1, slot0};
                  z_data       <= {rx, slot2};
                  sample_valid <= 1'b1;
                  idx          <= 2'd0;
                end else begin
                  idx <= idx + 2'd1;
                end
              end
            end else begin
              done <= 1'b1;
              if (frame_rd) begin
                rdata <= rx;
              end
            end
            // busy falls on the last CS-high cycle so the next frame can
            // launch exactly CS_GAP cycles after CS rises.
            if (CS_GAP > 1) begin
              gap_cnt <= 4'd1;
              state   <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        GAP: begin
          CS   <= 1'b1;
          MOSI <= 1'b0;
          if (gap_cnt >= GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          CS    <= 1'b1;
          MOSI  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
